// File: rtl/memory_access_pkg.sv
// Shared Y86 definitions for the pipeline stages: instruction codes,
// memory-stage state encoding and bus geometry.
package memory_access_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVQ  = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // A quad-word moves as this many byte beats.
  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/memory_access_addr_sel.sv
// Decodes an icode into the memory-stage operation: direction, byte
// address and the quad-word to be written.
module mem_addr_sel
  import memory_access_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] val_e,
  input  logic [63:0] val_a,
  input  logic [63:0] val_p,
  output logic        is_read,
  output logic        is_write,
  output logic [63:0] addr,
  output logic [63:0] wdata
);

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = val_e;
    wdata    = val_a;
    case (icode)
      I_RMMOVQ: is_write = 1'b1;
      I_PUSHQ:  is_write = 1'b1;
      I_CALL: begin
        is_write = 1'b1;
        wdata    = val_p;
      end
      I_MRMOVQ: is_read = 1'b1;
      // Stack pops read from the old stack pointer, not the ALU result.
      I_POPQ, I_RET: begin
        is_read = 1'b1;
        addr    = val_a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Y86 memory stage: moves one quad-word over an 8-bit request/ack bus as
// eight little-endian beats, with address-range and ack-timeout errors.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MEM_BYTES   = 1024,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [63:0] valM_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        dmem_error_o,
  output mem_state_t  state_o
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - WORD_BYTES);

  mem_state_t        state_q, state_d;
  logic              we_q;
  logic [63:0]       base_q;
  logic [63:0]       wdata_q;
  logic [2:0]        beat_q;
  logic [WAIT_W-1:0] wait_q;
  logic [63:0]       valm_q;
  logic              err_q;

  logic        sel_read, sel_write;
  logic [63:0] sel_addr, sel_wdata;
  logic        in_range, mem_op, timeout, last_beat, access;

  mem_addr_sel u_addr_sel (
    .icode    (icode_i),
    .val_e    (valE_i),
    .val_a    (valA_i),
    .val_p    (valP_i),
    .is_read  (sel_read),
    .is_write (sel_write),
    .addr     (sel_addr),
    .wdata    (sel_wdata)
  );

  assign mem_op    = sel_read | sel_write;
  assign in_range  = (sel_addr <= ADDR_MAX);
  assign access    = (state_q == ST_ACCESS);
  assign last_beat = (beat_q == 3'd7);
  assign timeout   = !mem_ack_i && (wait_q == WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (mem_op && in_range) ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: begin
        if ((mem_ack_i && last_beat) || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus handshake: while mem_req_o is high, addr/we/wdata stay fixed for the
  // current beat; a beat completes on a rising edge with mem_req_o && mem_ack_i.
  // Bus fields are forced to zero outside ACCESS.
  always_comb begin
    mem_req_o    = access;
    mem_we_o     = access && we_q;
    mem_addr_o   = access ? (base_q + 64'(beat_q)) : 64'd0;
    mem_wdata_o  = access ? wdata_q[{beat_q, 3'b000} +: 8] : 8'd0;
    done_o       = (state_q == ST_DONE);
    busy_o       = (state_q != ST_IDLE);
    valM_o       = valm_q;
    dmem_error_o = err_q;
    state_o      = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      base_q  <= 64'd0;
      wdata_q <= 64'd0;
      beat_q  <= 3'd0;
      wait_q  <= '0;
      valm_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            beat_q <= 3'd0;
            wait_q <= '0;
            if (mem_op && in_range) begin
              we_q    <= sel_write;
              base_q  <= sel_addr;
              wdata_q <= sel_wdata;
              valm_q  <= 64'd0;
              err_q   <= 1'b0;
            end else if (mem_op) begin
              // Out-of-range access keeps the previous valM.
              err_q <= 1'b1;
            end else begin
              valm_q <= 64'd0;
              err_q  <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            if (!we_q) valm_q[{beat_q, 3'b000} +: 8] <= mem_rdata_i;
            beat_q <= beat_q + 3'd1;
            wait_q <= '0;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: a byte-memory responder with programmable ack
// delay, a beat scoreboard and a per-operation result queue.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk, rst_n, start;
  logic [3:0]  icode;
  logic [63:0] val_e, val_a, val_p;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [63:0] val_m;
  logic        done, busy, dmem_error;
  mem_state_t  state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:1023];
  logic [72:0] exp_q[$];   // {we, addr, wdata} per expected beat
  logic [65:0] res_q[$];   // {check_valm, err, valm} per operation
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  int          beats_acked = 0;
  logic [63:0] last_valm;

  memory_access #(.MEM_BYTES(1024), .ACK_TIMEOUT(15)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .icode_i      (icode),
    .valE_i       (val_e),
    .valA_i       (val_a),
    .valP_i       (val_p),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .valM_o       (val_m),
    .done_o       (done),
    .busy_o       (busy),
    .dmem_error_o (dmem_error),
    .state_o      (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[10'(a + 64'(k))];
    return v;
  endfunction

  // Memory responder: acks each beat after ack_delay waiting cycles.
  initial begin : responder
    logic [63:0] hold_addr;
    logic [8:0]  hold_wd;
    logic [72:0] e;
    int          wait_n;
    wait_n = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_en) begin
        if (wait_n == 0) begin
          hold_addr = mem_addr;
          hold_wd   = {mem_we, mem_wdata};
        end else begin
          check("stable_addr", mem_addr, hold_addr);
          check("stable_we_wdata", 64'({mem_we, mem_wdata}), 64'(hold_wd));
        end
        if (wait_n == ack_delay) begin
          mem_ack = 1'b1;
          beats_acked++;
          wait_n = 0;
          check("beat_avail", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_we", 64'(mem_we), 64'(e[72]));
            check("beat_addr", mem_addr, e[71:8]);
            if (e[72]) check("beat_wdata", 64'(mem_wdata), 64'(e[7:0]));
          end
          if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[9:0]];
        end else begin
          mem_ack = 1'b0;
          wait_n++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_n = 0;
      end
    end
  end

  task automatic run_op(input string tag, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] va, input logic [63:0] vp, input logic exp_err,
                        input logic chk_valm, input logic [63:0] exp_valm, input int exp_cyc);
    bit          rd, wr;
    logic [63:0] addr, data;
    logic [65:0] r;
    int          cyc;
    rd   = ic inside {I_MRMOVQ, I_POPQ, I_RET};
    wr   = ic inside {I_RMMOVQ, I_PUSHQ, I_CALL};
    addr = (ic == I_POPQ || ic == I_RET) ? va : ve;
    data = (ic == I_CALL) ? vp : va;
    if ((rd || wr) && addr <= 64'd1016 && ack_en)
      for (int k = 0; k < 8; k++)
        exp_q.push_back({wr, addr + 64'(k), wr ? data[8*k +: 8] : 8'd0});
    res_q.push_back({chk_valm, exp_err, exp_valm});
    @(negedge clk);
    start = 1'b1; icode = ic; val_e = ve; val_a = va; val_p = vp;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    r = res_q.pop_front();
    check({tag, "_err"}, 64'(dmem_error), 64'(r[64]));
    if (r[65]) begin
      check({tag, "_valm"}, val_m, r[63:0]);
      last_valm = r[63:0];
    end
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    logic [63:0] a, d, popv;
    int          dl;
    rst_n = 1'b0; start = 1'b0; icode = I_NOP;
    val_e = '0; val_a = '0; val_p = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valm", val_m, 64'd0);
    check("rst_err", 64'(dmem_error), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("rmmovq", I_RMMOVQ, 64'h10, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b0, 64'h0, 10);
    run_op("mrmovq", I_MRMOVQ, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 10);
    run_op("ret", I_RET, 64'h999, 64'h10, 64'h0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 10);
    popv = model_read(64'h3F8);
    run_op("popq", I_POPQ, 64'h400, 64'h3F8, 64'h0, 1'b0, 1'b1, popv, 10);
    run_op("pushq_range", I_PUSHQ, 64'h3F9, 64'h55, 64'h0, 1'b1, 1'b1, popv, 2);
    run_op("opq", I_OPQ, 64'h10, 64'h20, 64'h0, 1'b0, 1'b1, 64'h0, 2);

    // start held through DONE must not launch a second operation
    @(negedge clk);
    start = 1'b1; icode = I_NOP;
    @(negedge clk);
    check("nop_done", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 64'(busy), 64'd0);

    ack_delay = 3;
    run_op("call", I_CALL, 64'h200, 64'h0, 64'h42, 1'b0, 1'b0, 64'h0, 34);
    ack_delay = 0;

    ack_en = 1'b0;
    run_op("timeout", I_MRMOVQ, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 17);
    ack_en = 1'b1;

    // Asynchronous reset in the middle of beat 4 of a write
    d = {$urandom(), $urandom()};
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 64'h300 + 64'(k), d[8*k +: 8]});
    beats_acked = 0;
    @(negedge clk);
    start = 1'b1; icode = I_RMMOVQ; val_e = 64'h300; val_a = d;
    @(negedge clk);
    start = 1'b0;
    dl = 0;
    while (beats_acked < 4 && dl < 100) begin
      @(negedge clk); #1;
      dl++;
    end
    check("rst_reach_beat4", 64'(beats_acked), 64'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 64'(mem_req), 64'd0);
    check("arst_we", 64'(mem_we), 64'd0);
    check("arst_addr", mem_addr, 64'd0);
    check("arst_wdata", 64'(mem_wdata), 64'd0);
    check("arst_valm", val_m, 64'd0);
    check("arst_err", 64'(dmem_error), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("arst_no_done", 64'(done), 64'd0);
    end
    exp_q.delete();
    rst_n = 1'b1;
    run_op("mrmovq_after_rst", I_MRMOVQ, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 10);

    for (int i = 0; i < 4; i++) begin
      a  = 64'($urandom_range(0, 1016));
      d  = {$urandom(), $urandom()};
      dl = $urandom_range(0, 3);
      ack_delay = dl;
      run_op("rnd_wr", I_RMMOVQ, a, d, 64'h0, 1'b0, 1'b0, 64'h0, 8 * (dl + 1) + 2);
      run_op("rnd_rd", I_MRMOVQ, a, 64'h0, 64'h0, 1'b0, 1'b1, d, 8 * (dl + 1) + 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
